// File: rtl/fp_add_pipe_pkg.sv
// Shared types and constants for the pipelined FP adder (default format: bfloat16).
package fpu_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 7;
   localparam int unsigned GRS_W  = 3;
   localparam int unsigned FLAG_W = 4;

   // Bit positions inside flags = {invalid, overflow, inexact, zero}
   localparam int unsigned FLAG_INVALID  = 3;
   localparam int unsigned FLAG_OVERFLOW = 2;
   localparam int unsigned FLAG_INEXACT  = 1;
   localparam int unsigned FLAG_ZERO     = 0;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp_t;

   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam fp_t QNAN = '{sign: 1'b0, exp: EXP_MAX, frac: {1'b1, {(FRAC_W-1){1'b0}}}};

endpackage

// File: rtl/fp_add_pipe_lzc.sv
// Leading-zero counter; all-zero input returns N.
module fp_lzc #(
   parameter  int unsigned N  = 8,
   localparam int unsigned CW = $clog2(N+1)
) (
   input  logic [N-1:0]  data_i,
   output logic [CW-1:0] count_c_o
);

   // Last set bit found while scanning upward is the most significant one
   always_comb begin
      count_c_o = CW'(N);
      for (int i = 0; i < int'(N); i++) begin
         if (data_i[i]) count_c_o = CW'(int'(N) - 1 - i);
      end
   end

endmodule

// File: rtl/fp_add_pipe.sv
// 3-stage pipelined FP add/subtract: S1 align, S2 add, S3 normalise+round (S3 reg = output).
// Optional feature macro: FP_ADD_PIPE_RNE_EN (round-to-nearest-even; otherwise truncate).
module fp_add_pipe
   import fpu_pkg::*;
#(
   parameter int unsigned EXP_WIDTH  = EXP_W,
   parameter int unsigned FRAC_WIDTH = FRAC_W,
   parameter int unsigned GRS_WIDTH  = GRS_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [EXP_WIDTH+FRAC_WIDTH:0] op1,
   input  logic [EXP_WIDTH+FRAC_WIDTH:0] op2,
   input  logic                          sub,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [EXP_WIDTH+FRAC_WIDTH:0] result,
   output logic [FLAG_W-1:0]             flags
);

   localparam int unsigned W   = 1 + EXP_WIDTH + FRAC_WIDTH;
   localparam int unsigned MW  = FRAC_WIDTH + 1 + GRS_WIDTH;
   localparam int unsigned LZW = $clog2(MW + 1);
   localparam int unsigned XW  = EXP_WIDTH + 2;
   localparam int unsigned MAG = EXP_WIDTH + FRAC_WIDTH;
   localparam logic [EXP_WIDTH-1:0] EMAX    = '1;
   localparam logic [W-1:0]         NAN_PAT = {1'b0, EMAX, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

   typedef struct packed {
      logic                  sign;
      logic [EXP_WIDTH-1:0]  exp;
      logic [FRAC_WIDTH-1:0] frac;
   } op_t;

   typedef struct packed {
      logic                 sign_a;
      logic                 eff_sub;
      logic [EXP_WIDTH-1:0] exp;
      logic [MW-1:0]        man_a;
      logic [MW-1:0]        man_b;
      logic                 spec;
      logic [W-1:0]         spec_res;
      logic [FLAG_W-1:0]    spec_flags;
   } s1_t;

   typedef struct packed {
      logic                 sign;
      logic [EXP_WIDTH-1:0] exp;
      logic [MW:0]          sum;
      logic                 spec;
      logic [W-1:0]         spec_res;
      logic [FLAG_W-1:0]    spec_flags;
   } s2_t;

   // Handshake / stage state
   logic              v1_q, v2_q, out_valid_q;
   s1_t               s1_q, s1_d;
   s2_t               s2_q, s2_d;
   logic [W-1:0]      result_q, result_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              en1_c, en2_c, en3_c;

   // S1 signals
   op_t                  a, b, hi, lo;
   logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, hi_zero, lo_zero;
   logic [MAG-1:0]       mag_a, mag_b;
   logic [EXP_WIDTH-1:0] diff;
   logic [MW-1:0]        man_lo, lost_mask;

   // S3 signals
   logic [LZW-1:0]        lz_c;
   logic [MW-1:0]         m;
   logic [XW-1:0]         e, e_r;
   logic [FRAC_WIDTH-1:0] frac_n, frac_r;
   logic                  grd, rnd, stk, lost;
`ifdef FP_ADD_PIPE_RNE_EN
   localparam int unsigned FW1 = FRAC_WIDTH + 1;
   logic                  rnd_up;
   logic [FRAC_WIDTH:0]   frac_inc;
`endif

   // Stage k loads when its register is empty or its content moves on
   assign en3_c    = ~out_valid_q | out_ready;
   assign en2_c    = ~v2_q | en3_c;
   assign en1_c    = ~v1_q | en2_c;
   assign in_ready = en1_c;

   // S1: classify specials, order by magnitude, align smaller operand with sticky
   always_comb begin
      a      = op_t'(op1);
      b      = op_t'(op2);
      b.sign = op2[W-1] ^ sub;

      a_zero = ~(|a.exp);
      b_zero = ~(|b.exp);
      a_nan  = (&a.exp) & (|a.frac);
      b_nan  = (&b.exp) & (|b.frac);
      a_inf  = (&a.exp) & ~(|a.frac);
      b_inf  = (&b.exp) & ~(|b.frac);

      mag_a = a_zero ? '0 : {a.exp, a.frac};
      mag_b = b_zero ? '0 : {b.exp, b.frac};

      if (mag_b > mag_a) begin
         hi = b; lo = a; hi_zero = b_zero; lo_zero = a_zero;
      end else begin
         hi = a; lo = b; hi_zero = a_zero; lo_zero = b_zero;
      end

      diff      = hi.exp - lo.exp;
      man_lo    = lo_zero ? '0 : {1'b1, lo.frac, {GRS_WIDTH{1'b0}}};
      lost_mask = ~({MW{1'b1}} << diff);

      s1_d         = '0;
      s1_d.sign_a  = hi.sign;
      s1_d.eff_sub = hi.sign ^ lo.sign;
      s1_d.exp     = hi.exp;
      s1_d.man_a   = hi_zero ? '0 : {1'b1, hi.frac, {GRS_WIDTH{1'b0}}};
      // Shift >= width yields zero, and the mask then covers every bit -> sticky only
      s1_d.man_b   = (man_lo >> diff) | MW'(|(man_lo & lost_mask));
      s1_d.spec    = a_nan | b_nan | a_inf | b_inf;
      s1_d.spec_res = W'(a);
      if (a_nan | b_nan) begin
         s1_d.spec_res = NAN_PAT;
      end else if (a_inf & b_inf & (a.sign ^ b.sign)) begin
         s1_d.spec_res                 = NAN_PAT;
         s1_d.spec_flags[FLAG_INVALID] = 1'b1;
      end else if (a_inf) begin
         s1_d.spec_res = W'(a);
      end else begin
         s1_d.spec_res = W'(b);
      end
   end

   // S2: magnitude add/subtract; A >= B so the difference is never negative
   always_comb begin
      s2_d            = '0;
      s2_d.exp        = s1_q.exp;
      s2_d.spec       = s1_q.spec;
      s2_d.spec_res   = s1_q.spec_res;
      s2_d.spec_flags = s1_q.spec_flags;
      if (s1_q.eff_sub) s2_d.sum = {1'b0, s1_q.man_a} - {1'b0, s1_q.man_b};
      else              s2_d.sum = {1'b0, s1_q.man_a} + {1'b0, s1_q.man_b};
      s2_d.sign = (s1_q.eff_sub && (s2_d.sum == '0)) ? 1'b0 : s1_q.sign_a;
   end

   fp_lzc #(.N(MW)) u_lzc (
      .data_i    (s2_q.sum[MW-1:0]),
      .count_c_o (lz_c)
   );

   // S3: normalise, round, then resolve zero / underflow / overflow / specials
   always_comb begin
      if (s2_q.sum[MW]) begin
         m = s2_q.sum[MW:1] | MW'(s2_q.sum[0]);
         e = XW'(s2_q.exp) + XW'(1);
      end else begin
         m = s2_q.sum[MW-1:0] << lz_c;
         e = XW'(s2_q.exp) - XW'(lz_c);
      end
      frac_n = m[MW-2:GRS_WIDTH];
      grd    = m[GRS_WIDTH-1];
      rnd    = m[GRS_WIDTH-2];
      stk    = |m[GRS_WIDTH-3:0];
      lost   = grd | rnd | stk;
`ifdef FP_ADD_PIPE_RNE_EN
      rnd_up   = grd & (rnd | stk | m[GRS_WIDTH]);
      frac_inc = {1'b0, frac_n} + FW1'(rnd_up);
      frac_r   = frac_inc[FRAC_WIDTH-1:0];
      e_r      = e + XW'(frac_inc[FRAC_WIDTH]);
`else
      frac_r = frac_n;
      e_r    = e;
`endif

      result_d = '0;
      flags_d  = '0;
      if (s2_q.spec) begin
         result_d = s2_q.spec_res;
         flags_d  = s2_q.spec_flags;
      end else if (~m[MW-1]) begin
         // Normalised hidden bit clear only when the sum is exactly zero
         result_d             = {s2_q.sign, {(W-1){1'b0}}};
         flags_d[FLAG_ZERO]   = 1'b1;
      end else if (e[XW-1] || (e == '0)) begin
         result_d              = {s2_q.sign, {(W-1){1'b0}}};
         flags_d[FLAG_ZERO]    = 1'b1;
         flags_d[FLAG_INEXACT] = 1'b1;
      end else if (e_r >= XW'(EMAX)) begin
         result_d               = {s2_q.sign, EMAX, {FRAC_WIDTH{1'b0}}};
         flags_d[FLAG_OVERFLOW] = 1'b1;
         flags_d[FLAG_INEXACT]  = 1'b1;
      end else begin
         result_d              = {s2_q.sign, e_r[EXP_WIDTH-1:0], frac_r};
         flags_d[FLAG_INEXACT] = lost;
      end
   end

   // Pipeline registers; a stage only loads payload when the upstream stage holds a valid op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         s1_q        <= '0;
         s2_q        <= '0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         if (en1_c) begin
            v1_q <= in_valid;
            if (in_valid) s1_q <= s1_d;
         end
         if (en2_c) begin
            v2_q <= v1_q;
            if (v1_q) s2_q <= s2_d;
         end
         if (en3_c) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
               result_q <= result_d;
               flags_q  <= flags_d;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed testbench for fp_add_pipe (bfloat16 default format).
module tb_fp_add_pipe;
   import fpu_pkg::*;

`ifdef FP_ADD_PIPE_RNE_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   localparam logic [15:0] INF_P = {1'b0, EXP_MAX, 7'h00};

   logic        clk, rst_n, in_valid, in_ready, sub, out_valid, out_ready;
   logic [15:0] op1, op2, result;
   logic [3:0]  flags;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] res;
      logic [3:0]  flg;
      string       name;
   } vec_t;

   vec_t vecs[$];

   fp_add_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op1       (op1),
      .op2       (op2),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   task automatic add_vec(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [15:0] r, input logic [3:0] f, input string nm);
      vec_t v;
      v.a = a; v.b = b; v.sub = s; v.res = r; v.flg = f; v.name = nm;
      vecs.push_back(v);
   endtask

   // One op through an idle pipeline: accept, measure latency, check result and flags
   task automatic run_vec(input vec_t v);
      int lat;
      @(negedge clk);
      op1 = v.a; op2 = v.b; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         #1;
         lat++;
      end
      check({v.name, " latency"}, 32'(lat), 32'd3);
      check({v.name, " result"}, 32'(result), 32'(v.res));
      check({v.name, " flags"}, 32'(flags), 32'(v.flg));
   endtask

   logic [15:0] bp_a[5];
   logic [15:0] bp_r[5];

   initial begin
      int idx, recv, cyc;
      logic seen;

      rst_n = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; sub = 1'b0; out_ready = 1'b1;

      add_vec(16'h3F80, 16'h3F80, 1'b0, 16'h4000, 4'b0000, "one_plus_one");
      add_vec(16'h4040, 16'h4040, 1'b1, 16'h0000, 4'b0001, "three_minus_three");
      add_vec(16'h3F80, 16'hBF80, 1'b0, 16'h0000, 4'b0001, "one_plus_neg_one");
      add_vec(16'h3F80, 16'h3C40, 1'b0, RNE ? 16'h3F82 : 16'h3F81, 4'b0010, "one_plus_1p5ulp");
      add_vec(16'h7F7F, 16'h7F7F, 1'b0, INF_P, 4'b0110, "max_plus_max");
      add_vec(16'h7F80, 16'h7F80, 1'b1, QNAN, 4'b1000, "inf_minus_inf");
      add_vec(16'h7FC1, 16'h3F80, 1'b0, QNAN, 4'b0000, "nan_in");
      add_vec(16'hFF80, 16'h3F80, 1'b0, 16'hFF80, 4'b0000, "neg_inf_plus_one");
      add_vec(16'h7F80, 16'h3F80, 1'b1, 16'h7F80, 4'b0000, "inf_minus_one");
      add_vec(16'h0000, 16'h8000, 1'b0, 16'h0000, 4'b0001, "pz_plus_nz");
      add_vec(16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0001, "nz_plus_nz");
      add_vec(16'h4000, 16'h3F80, 1'b1, 16'h3F80, 4'b0000, "two_minus_one");
      add_vec(16'h3F80, 16'h4000, 1'b1, 16'hBF80, 4'b0000, "one_minus_two");
      add_vec(16'h0001, 16'h3F80, 1'b0, 16'h3F80, 4'b0000, "denorm_flushed");
      add_vec(16'h0080, 16'h00C0, 1'b1, 16'h8000, 4'b0011, "underflow_flush");
      add_vec(16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 4'b0010, "tie_to_even_down");
      add_vec(16'h3F81, 16'h3B80, 1'b0, RNE ? 16'h3F82 : 16'h3F81, 4'b0010, "tie_to_even_up");
      add_vec(16'h3FFF, 16'h3B80, 1'b0, RNE ? 16'h4000 : 16'h3FFF, 4'b0010, "round_carry");
      add_vec(16'h3F80, 16'h3000, 1'b0, 16'h3F80, 4'b0010, "far_sticky");
      add_vec(16'h7F7F, 16'h7B00, 1'b0, RNE ? INF_P : 16'h7F7F, RNE ? 4'b0110 : 4'b0010,
              "round_overflow");

      bp_a[0] = 16'h3F80; bp_r[0] = 16'h4000;
      bp_a[1] = 16'h4000; bp_r[1] = 16'h4080;
      bp_a[2] = 16'h4040; bp_r[2] = 16'h40C0;
      bp_a[3] = 16'h4080; bp_r[3] = 16'h4100;
      bp_a[4] = 16'h40A0; bp_r[4] = 16'h4120;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst flags", 32'(flags), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("rst in_ready", 32'(in_ready), 32'd1);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure: stalled output fills the three stages, result held, then drains in order
      @(negedge clk);
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         in_valid = (idx < 5);
         if (idx < 5) begin op1 = bp_a[idx]; op2 = bp_a[idx]; sub = 1'b0; end
         #1;
         if (out_valid) begin
            check("bp held result", 32'(result), 32'(bp_r[0]));
            check("bp held flags", 32'(flags), 32'd0);
         end
         if (in_valid && in_ready) idx++;
      end
      check("bp accepted count", 32'(idx), 32'd3);
      check("bp in_ready low", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);

      recv = 0;
      cyc  = 0;
      while (recv < 5 && cyc < 30) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = (idx < 5);
         if (idx < 5) begin op1 = bp_a[idx]; op2 = bp_a[idx]; end
         #1;
         if (out_valid) begin
            check("bp drain order", 32'(result), 32'(bp_r[recv]));
            recv++;
         end
         if (in_valid && in_ready) idx++;
         cyc++;
      end
      check("bp drained count", 32'(recv), 32'd5);
      @(negedge clk);
      in_valid = 1'b0;

      // Reset with three ops in flight
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b1; op1 = bp_a[c]; op2 = bp_a[c]; sub = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("pre-reset out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async reset out_valid", 32'(out_valid), 32'd0);
      check("async reset result", 32'(result), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("no stale after reset", 32'(seen), 32'd0);
      run_vec(vecs[0]);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
